// File: rtl/gshare_predictor_pkg.sv
// Shared definitions for the gshare branch predictor: counter encodings,
// default address width and the saturating-counter step helper.
package gshare_predictor_pkg;

  localparam int unsigned ADDR_W_DEF = 32;

  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } ctr_e;

  // One step of a 2-bit saturating counter towards taken / not-taken.
  function automatic ctr_e ctr_step(input ctr_e cur, input logic taken);
    ctr_e nxt;
    nxt = cur;
    unique case (cur)
      SNT: nxt = taken ? WNT : SNT;
      WNT: nxt = taken ? WT  : SNT;
      WT:  nxt = taken ? ST  : WNT;
      ST:  nxt = taken ? ST  : WT;
      default: nxt = WNT;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/gshare_predictor_sat_counter2.sv
// Next-state logic for one 2-bit saturating direction counter.
module sat_counter2
  import gshare_predictor_pkg::*;
(
  input  logic [1:0] cur,
  input  logic       taken,
  output logic [1:0] nxt
);

  // Saturate at strongly-taken / strongly-not-taken.
  always_comb begin
    nxt = ctr_step(ctr_e'(cur), taken);
  end

endmodule

// File: rtl/gshare_predictor.sv
// Gshare / bimodal branch direction predictor with a speculative global
// history for queries, a committed history for training, and retirement
// statistics.
module gshare_predictor
  import gshare_predictor_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned IDX_W  = 8,
  parameter int unsigned GHR_W  = 8,
  parameter int unsigned MODE   = 1
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              clr_in,
  input  logic              if_to_pr_valid,
  input  logic [ADDR_W-1:0] if_to_pr_PC,
  input  logic [ADDR_W-1:0] if_to_pr_imm,
  output logic              pr_to_if_predict_taken,
  output logic [ADDR_W-1:0] pr_to_if_predict_PC,
  input  logic              rob_to_pr_br_commit,
  input  logic [ADDR_W-1:0] rob_to_pr_br_PC,
  input  logic              rob_to_pr_br_taken,
  input  logic              rob_to_pr_br_mispredict,
  output logic [31:0]       pr_br_count,
  output logic [31:0]       pr_miss_count
);

  localparam int unsigned DEPTH = 1 << IDX_W;

  logic [1:0]       bht [DEPTH];
  logic [GHR_W-1:0] spec_ghr;
  logic [GHR_W-1:0] commit_ghr;

  logic [IDX_W-1:0] q_idx;
  logic [IDX_W-1:0] c_idx;
  logic [1:0]       q_ctr;
  logic [1:0]       c_ctr;
  logic [1:0]       c_ctr_nxt;
  logic [GHR_W-1:0] commit_ghr_nxt;
  logic [GHR_W-1:0] spec_ghr_shift;
  logic             unused_rob_pc_bits;

  // Only the word-index bits of the retiring PC address the table.
  assign unused_rob_pc_bits = ^{rob_to_pr_br_PC[ADDR_W-1:IDX_W+2], rob_to_pr_br_PC[1:0]};

  // Query path: index hash, counter lookup and next-PC selection.
  always_comb begin
    q_idx = if_to_pr_PC[IDX_W+1:2];
    if (MODE != 0) q_idx = q_idx ^ IDX_W'(spec_ghr);
    q_ctr                  = bht[q_idx];
    pr_to_if_predict_taken = q_ctr[1];
    pr_to_if_predict_PC    = q_ctr[1] ? (if_to_pr_PC + if_to_pr_imm)
                                      : (if_to_pr_PC + ADDR_W'(4));
  end

  // Commit path: training index, selected counter and shifted histories.
  always_comb begin
    c_idx = rob_to_pr_br_PC[IDX_W+1:2];
    if (MODE != 0) c_idx = c_idx ^ IDX_W'(commit_ghr);
    c_ctr          = bht[c_idx];
    commit_ghr_nxt = rob_to_pr_br_commit ? ((commit_ghr << 1) | GHR_W'(rob_to_pr_br_taken))
                                         : commit_ghr;
    spec_ghr_shift = (spec_ghr << 1) | GHR_W'(pr_to_if_predict_taken);
  end

  sat_counter2 u_sat_counter2 (
    .cur   (c_ctr),
    .taken (rob_to_pr_br_taken),
    .nxt   (c_ctr_nxt)
  );

  // Branch history table: trained only by retiring branches.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int unsigned i = 0; i < DEPTH; i++) bht[i] <= WNT;
    end else if (rdy_in && rob_to_pr_br_commit) begin
      bht[c_idx] <= c_ctr_nxt;
    end
  end

  // Global histories; a flush rebuilds speculative history from the
  // committed one, already including any branch retiring this cycle.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      spec_ghr   <= '0;
      commit_ghr <= '0;
    end else if (rdy_in) begin
      commit_ghr <= commit_ghr_nxt;
      if (clr_in) begin
        spec_ghr <= commit_ghr_nxt;
      end else if (if_to_pr_valid) begin
        spec_ghr <= spec_ghr_shift;
      end
    end
  end

  // Retired-branch and mispredict statistics, free-running wrap.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      pr_br_count   <= '0;
      pr_miss_count <= '0;
    end else if (rdy_in && rob_to_pr_br_commit) begin
      pr_br_count <= pr_br_count + 32'd1;
      if (rob_to_pr_br_mispredict) pr_miss_count <= pr_miss_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_gshare_predictor.sv
// Directed bench for gshare_predictor: one bimodal and one gshare instance
// share stimulus; prediction expectations go through a scoreboard queue.
module tb_gshare_predictor;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        clr_in;
  logic        if_to_pr_valid;
  logic [31:0] if_to_pr_PC;
  logic [31:0] if_to_pr_imm;
  logic        rob_to_pr_br_commit;
  logic [31:0] rob_to_pr_br_PC;
  logic        rob_to_pr_br_taken;
  logic        rob_to_pr_br_mispredict;

  logic        t0, t1;
  logic [31:0] p0, p1;
  logic [31:0] br0, br1, miss0, miss1;

  typedef struct {
    logic        t0;
    logic [31:0] p0;
    logic        t1;
    logic [31:0] p1;
    string       name;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk_in = ~clk_in;

  gshare_predictor #(.ADDR_W(32), .IDX_W(8), .GHR_W(8), .MODE(0)) u0 (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clr_in(clr_in),
    .if_to_pr_valid(if_to_pr_valid), .if_to_pr_PC(if_to_pr_PC), .if_to_pr_imm(if_to_pr_imm),
    .pr_to_if_predict_taken(t0), .pr_to_if_predict_PC(p0),
    .rob_to_pr_br_commit(rob_to_pr_br_commit), .rob_to_pr_br_PC(rob_to_pr_br_PC),
    .rob_to_pr_br_taken(rob_to_pr_br_taken), .rob_to_pr_br_mispredict(rob_to_pr_br_mispredict),
    .pr_br_count(br0), .pr_miss_count(miss0)
  );

  gshare_predictor #(.ADDR_W(32), .IDX_W(8), .GHR_W(8), .MODE(1)) u1 (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clr_in(clr_in),
    .if_to_pr_valid(if_to_pr_valid), .if_to_pr_PC(if_to_pr_PC), .if_to_pr_imm(if_to_pr_imm),
    .pr_to_if_predict_taken(t1), .pr_to_if_predict_PC(p1),
    .rob_to_pr_br_commit(rob_to_pr_br_commit), .rob_to_pr_br_PC(rob_to_pr_br_PC),
    .rob_to_pr_br_taken(rob_to_pr_br_taken), .rob_to_pr_br_mispredict(rob_to_pr_br_mispredict),
    .pr_br_count(br1), .pr_miss_count(miss1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: every presented query is compared against the oldest expectation.
  always @(negedge clk_in) begin
    if (rst_in === 1'b1 && if_to_pr_valid === 1'b1) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_query actual=%h required=none", if_to_pr_PC);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk({e.name, "_m0_taken"}, 32'(t0), 32'(e.t0));
        chk({e.name, "_m0_pc"}, p0, e.p0);
        chk({e.name, "_m1_taken"}, 32'(t1), 32'(e.t1));
        chk({e.name, "_m1_pc"}, p1, e.p1);
      end
    end
  end

  task automatic idle();
    rdy_in = 1'b1; clr_in = 1'b0; if_to_pr_valid = 1'b0;
    if_to_pr_PC = '0; if_to_pr_imm = '0;
    rob_to_pr_br_commit = 1'b0; rob_to_pr_br_PC = '0;
    rob_to_pr_br_taken = 1'b0; rob_to_pr_br_mispredict = 1'b0;
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_query(input string name, input logic [31:0] pc, input logic [31:0] imm,
                           input logic et0, input logic [31:0] ep0,
                           input logic et1, input logic [31:0] ep1);
    exp_t e;
    if_to_pr_valid = 1'b1; if_to_pr_PC = pc; if_to_pr_imm = imm;
    e.t0 = et0; e.p0 = ep0; e.t1 = et1; e.p1 = ep1; e.name = name;
    q.push_back(e);
  endtask

  task automatic set_commit(input logic [31:0] pc, input logic tk, input logic miss);
    rob_to_pr_br_commit = 1'b1; rob_to_pr_br_PC = pc;
    rob_to_pr_br_taken = tk; rob_to_pr_br_mispredict = miss;
  endtask

  task automatic commit1(input logic [31:0] pc, input logic tk);
    set_commit(pc, tk, 1'b0); step(); idle();
  endtask

  task automatic do_reset();
    idle(); rst_in = 1'b0; step(); step(); rst_in = 1'b1; step();
  endtask

  initial begin
    idle();
    rst_in = 1'b0;
    step();
    // Reset held while commit, flush and query are all active.
    set_commit(32'h1000, 1'b1, 1'b1); clr_in = 1'b1; if_to_pr_valid = 1'b1;
    step();
    idle(); rst_in = 1'b1;
    step();
    chk("rst_br_count", br1, 32'd0);
    chk("rst_miss_count", miss1, 32'd0);
    chk("rst_spec_ghr", 32'(u1.spec_ghr), 32'h0);
    chk("rst_commit_ghr", 32'(u1.commit_ghr), 32'h0);
    set_query("rst_query", 32'h1000, 32'h40, 1'b0, 32'h1004, 1'b0, 32'h1004);
    step(); idle();

    // Training and saturation at the top of the counter.
    do_reset();
    commit1(32'h1000, 1'b1);
    commit1(32'h1000, 1'b1);
    set_query("train2", 32'h1000, 32'h40, 1'b1, 32'h1040, 1'b1, 32'h1040);
    step(); idle();
    commit1(32'h1000, 1'b1);
    commit1(32'h1000, 1'b0);
    set_query("sat_hi", 32'h1000, 32'h40, 1'b1, 32'h1040, 1'b1, 32'h1040);
    step(); idle();
    chk("train_br_count", br0, 32'd4);
    chk("train_miss_count", miss0, 32'd0);

    // Speculative history build-up and flush with a same-cycle query.
    do_reset();
    for (int i = 0; i < 3; i++) commit1(32'h1000, 1'b1);
    for (int i = 0; i < 7; i++) commit1(32'h1040, 1'b0);
    commit1(32'h1040, 1'b1);
    chk("pre_clr_commit_ghr", 32'(u1.commit_ghr), 32'h01);
    for (int i = 0; i < 3; i++) begin
      set_query("ghr_q", 32'h1000, 32'h40, 1'b1, 32'h1040, 1'b1, 32'h1040);
      step(); idle();
    end
    chk("spec_ghr_3taken_m1", 32'(u1.spec_ghr), 32'h07);
    chk("spec_ghr_3taken_m0", 32'(u0.spec_ghr), 32'h07);
    clr_in = 1'b1;
    set_query("clr_q", 32'h1000, 32'h40, 1'b1, 32'h1040, 1'b0, 32'h1004);
    step(); idle();
    chk("clr_spec_ghr", 32'(u1.spec_ghr), 32'h01);
    chk("clr_br_count", br1, 32'd11);

    // Flush in the same cycle as a mispredicted taken commit.
    do_reset();
    set_commit(32'h1000, 1'b1, 1'b1); clr_in = 1'b1;
    step(); idle();
    chk("clrc_spec_ghr", 32'(u1.spec_ghr), 32'h01);
    chk("clrc_commit_ghr", 32'(u1.commit_ghr), 32'h01);
    chk("clrc_br_count", br1, 32'd1);
    chk("clrc_miss_count", miss1, 32'd1);

    // Stall: everything asserted with rdy_in low changes nothing.
    rdy_in = 1'b0; clr_in = 1'b1;
    set_commit(32'h1000, 1'b0, 1'b1);
    set_query("stall_q", 32'h1000, 32'h40, 1'b1, 32'h1040, 1'b0, 32'h1004);
    step(); idle();
    chk("stall_spec_ghr", 32'(u1.spec_ghr), 32'h01);
    chk("stall_commit_ghr", 32'(u1.commit_ghr), 32'h01);
    chk("stall_br_count", br1, 32'd1);
    chk("stall_miss_count", miss1, 32'd1);
    set_query("post_stall_q", 32'h1000, 32'h40, 1'b1, 32'h1040, 1'b0, 32'h1004);
    step(); idle();

    // Same-cycle query sees the pre-update counter; then address wrap.
    do_reset();
    set_commit(32'hFFFF_FFFC, 1'b1, 1'b0);
    set_query("fwd_pre", 32'hFFFF_FFFC, 32'h8, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000);
    step(); idle();
    commit1(32'hFFFF_FFFC, 1'b1);
    set_query("wrap", 32'hFFFF_FFFC, 32'h8, 1'b1, 32'h0000_0004, 1'b1, 32'h0000_0004);
    step(); idle();

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 20 && q.size() != 0; i++) step();
    chk("scoreboard_drained", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gshare_predictor.md
GSHARE_PREDICTOR -- requirements
Module: gshare_predictor

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter IDX_W, default 8, BHT index bits (2^IDX_W entries of 2-bit counters).
REQ-003 SHALL have parameter GHR_W, default 8, global history bits; legal range 1..IDX_W.
REQ-004 SHALL have parameter MODE, default 1, 0 = bimodal, 1 = gshare.
REQ-005 SHALL have port clk_in  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port rst_in  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port rdy_in  input  1  global enable; low freezes all state.
REQ-008 SHALL have port clr_in  input  1  pipeline flush on mispredict.
REQ-009 SHALL have port if_to_pr_valid  input  1  branch query this cycle.
REQ-010 SHALL have port if_to_pr_PC  input  ADDR_W  branch PC.
REQ-011 SHALL have port if_to_pr_imm  input  ADDR_W  sign-extended branch offset.
REQ-012 SHALL have port pr_to_if_predict_taken  output  1  predicted direction.
REQ-013 SHALL have port pr_to_if_predict_PC  output  ADDR_W  predicted next PC.
REQ-014 SHALL have port rob_to_pr_br_commit  input  1  conditional branch retires.
REQ-015 SHALL have port rob_to_pr_br_PC  input  ADDR_W  retiring branch PC.
REQ-016 SHALL have port rob_to_pr_br_taken  input  1  resolved direction.
REQ-017 SHALL have port rob_to_pr_br_mispredict  input  1  retiring branch was mispredicted.
REQ-018 SHALL have ports pr_br_count and pr_miss_count  output  32 each  retired-branch and mispredict statistics.

Function
REQ-019 Query index SHALL be PC[IDX_W+1:2] XOR (MODE ? spec_ghr zero-extended to IDX_W : 0); combinational, zero latency.
REQ-020 pr_to_if_predict_taken SHALL equal bit 1 of the indexed counter; predict_PC SHALL be taken ? PC+imm : PC+4, modulo 2^ADDR_W.
REQ-021 Outputs SHALL be driven regardless of if_to_pr_valid; consumers qualify them.
REQ-022 On edge with rdy_in & if_to_pr_valid & !clr_in, spec_ghr SHALL shift left inserting predicted taken.
REQ-023 On edge with rdy_in & rob_to_pr_br_commit, the counter at rob PC[IDX_W+1:2] XOR (MODE ? commit_ghr : 0) SHALL increment on taken, decrement on not-taken, saturating at 3 and 0.
REQ-024 Same commit SHALL shift rob_to_pr_br_taken into commit_ghr, increment pr_br_count, and increment pr_miss_count if mispredict; counters wrap at 2^32.
REQ-025 On edge with rdy_in & clr_in, spec_ghr SHALL load commit_ghr including any same-cycle commit shift; a same-cycle query SHALL be ignored.
REQ-026 Query and commit to same index in one cycle: query SHALL see pre-update counter value.
REQ-027 rdy_in low SHALL hold every register, including across clr_in and commit.
REQ-028 MODE 0 SHALL still maintain both GHRs but not use them for indexing.

Reset
REQ-029 rst_in low SHALL asynchronously set all counters to 2'b01, spec_ghr and commit_ghr to 0, both statistics to 0.
REQ-030 After reset pr_to_if_predict_taken SHALL be 0 and predict_PC SHALL be PC+4 for any PC.
REQ-031 Reset asserted mid-operation SHALL override clr_in, commit and query in that cycle.

Structure
REQ-032 Counter encoding constants (SNT=0, WNT=1, WT=2, ST=3) and the ADDR_W default SHALL live in the shared package.
REQ-033 One sub-module sat_counter2 (2-bit saturating next-state logic) SHALL be instantiated for the update path; BHT storage SHALL be a register array.

Verification
REQ-034 Reset, query PC=0x1000 imm=0x40 -> taken=0, predict_PC=0x1004.
REQ-035 MODE=0: two taken commits for PC=0x1000 -> query PC=0x1000 imm=0x40 gives taken=1, predict_PC=0x1040; third taken commit keeps counter at 3.
REQ-036 MODE=1, GHR_W=8: three taken queries -> spec_ghr=0x07; clr_in with commit_ghr=0x01 -> spec_ghr=0x01 next cycle.
REQ-037 Simultaneous commit (taken, mispredict) and clr_in with commit_ghr=0x00 -> spec_ghr=0x01, pr_br_count=1, pr_miss_count=1.
REQ-038 rdy_in=0 while commit, query and clr_in asserted -> no register changes.
REQ-039 PC=0xFFFFFFFC, imm=0x8, counter=3 -> predict_PC=0x00000004 (wrap).
